// File: rtl/rvvi_stream_packetizer.sv
// rvvi_stream_packetizer: buffers wide RVVI frames in a small FIFO and
// serializes each one as a header beat plus payload beats on a ready/valid stream.
module rvvi_stream_packetizer #(
  parameter int RVVI_WIDTH        = 784,
  parameter int FRAME_COUNT_WIDTH = 16,
  parameter int OUT_WIDTH         = 32,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          DutValid,
  input  logic [RVVI_WIDTH-1:0]         DutRvvi,
  input  logic [FRAME_COUNT_WIDTH-1:0]  DutFrameCount,
  output logic [OUT_WIDTH-1:0]          TData,
  output logic                          TValid,
  output logic                          TLast,
  input  logic                          TReady,
  output logic [15:0]                   DropCount,
  output logic                          Overflow,
  output logic [$clog2(FIFO_DEPTH):0]   FifoLevel
);

  localparam int NBEATS = (RVVI_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
  localparam int PW     = NBEATS * OUT_WIDTH;
  localparam int EW     = FRAME_COUNT_WIDTH + RVVI_WIDTH;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wptr, rptr;
  logic          full, empty, push, pop, drop, more;
  state_t        state;
  logic [BW-1:0] beat;
  logic [EW-1:0] head;
  logic [PW-1:0] head_pad;

  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
  assign FifoLevel = wptr - rptr;
  assign pop       = TValid & TReady & TLast;
  assign push      = DutValid & (~full | pop);
  assign drop      = DutValid & full & ~pop;
  // another entry remains after this pop, counting a same-cycle push
  assign more      = (FifoLevel > 1) | push;

  assign head     = mem[rptr[AW-1:0]];
  assign head_pad = PW'(head[RVVI_WIDTH-1:0]);

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= {DutFrameCount, DutRvvi};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      DropCount <= '0;
      Overflow  <= 1'b0;
    end else if (drop) begin
      Overflow <= 1'b1;
      if (DropCount != 16'hFFFF) DropCount <= DropCount + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      beat   <= '0;
      TValid <= 1'b0;
      TLast  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            state  <= HEADER;
            TValid <= 1'b1;
          end
        end
        HEADER: begin
          if (TReady) begin
            state <= PAYLOAD;
            beat  <= '0;
            TLast <= 1'(NBEATS == 1);
          end
        end
        PAYLOAD: begin
          if (TReady) begin
            if (!TLast) begin
              beat  <= beat + 1'b1;
              TLast <= (beat == BW'(NBEATS - 2));
            end else if (more) begin
              state <= HEADER;
              TLast <= 1'b0;
            end else begin
              state  <= IDLE;
              TValid <= 1'b0;
              TLast  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    TData = '0;
    unique case (1'b1)
      (state == HEADER):
        TData = OUT_WIDTH'({16'(head[EW-1 -: FRAME_COUNT_WIDTH]),
                            8'(NBEATS), 8'h5A});
      (state == PAYLOAD):
        TData = head_pad[beat*OUT_WIDTH +: OUT_WIDTH];
      default: ;
    endcase
  end

endmodule
